// File: rtl/inf_send_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inf_send_pkg
// Purpose  : NEC IR transmitter timing/carrier defaults, FSM state encoding
//            and a burst-state classifier shared by the inf_send files.
// Revision : 1.0  initial release
// ============================================================================
package inf_send_pkg;

    // Default timings in 50 MHz sys_clk cycles
    localparam int unsigned c_CNT_CAR   = 1316;       // 38 kHz carrier period
    localparam int unsigned c_CNT_CAR_H = 439;        // 1/3 duty high time
    localparam int unsigned c_T_LEAD_H  = 450_000;    // 9 ms leader burst
    localparam int unsigned c_T_LEAD_L  = 225_000;    // 4.5 ms leader space
    localparam int unsigned c_T_REP_L   = 112_500;    // 2.25 ms repeat space
    localparam int unsigned c_T_BIT_H   = 28_000;     // 560 us bit/stop burst
    localparam int unsigned c_T_ZERO_L  = 28_000;     // 560 us logic-0 space
    localparam int unsigned c_T_ONE_L   = 84_500;     // 1.69 ms logic-1 space
    localparam int unsigned c_T_FRAME   = 5_500_000;  // 110 ms frame period

    localparam int unsigned c_FRAME_W   = 23;         // frame/phase counter width

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEAD_H = 4'd1,
        S_LEAD_L = 4'd2,
        S_BIT_H  = 4'd3,
        S_BIT_L  = 4'd4,
        S_STOP_H = 4'd5,
        S_GAP    = 4'd6,
        S_REP_H  = 4'd7,
        S_REP_L  = 4'd8
    } state_t;

    // States during which the LED carries the modulated carrier
    function automatic logic is_burst(input state_t s);
        return (s == S_LEAD_H) || (s == S_BIT_H) || (s == S_STOP_H) || (s == S_REP_H);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inf_send_carrier.sv
`default_nettype none
// ============================================================================
// Module   : inf_carrier
// Purpose  : 38 kHz carrier counter with restart, gated by the burst envelope.
//            Output is registered (one cycle behind the envelope).
// Revision : 1.0  initial release
// ============================================================================
module inf_carrier #(
    parameter int unsigned CNT_CAR   = 1316,
    parameter int unsigned CNT_CAR_H = 439
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,   // next cycle is the first cycle of a burst
    input  logic i_burst,     // current state is a burst state
    output logic o_out
);

    localparam int unsigned c_W = (CNT_CAR > 1) ? $clog2(CNT_CAR) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(CNT_CAR - 1);
    localparam logic [c_W-1:0] c_HIGH = c_W'(CNT_CAR_H);

    logic [c_W-1:0] r_car_cnt;
    logic           r_out;

    // Carrier phase: zero on burst entry, then wraps every CNT_CAR cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car_cnt <= '0;
        end else if (i_restart || (r_car_cnt == c_LAST)) begin
            r_car_cnt <= '0;
        end else begin
            r_car_cnt <= r_car_cnt + 1'b1;
        end
    end

    // Registered LED drive: high for the first CNT_CAR_H cycles of each period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 1'b0;
        end else begin
            r_out <= i_burst && (r_car_cnt < c_HIGH);
        end
    end

    assign o_out = r_out;

endmodule
`default_nettype wire

// File: rtl/inf_send.sv
`default_nettype none
// ============================================================================
// Module   : inf_send
// Purpose  : NEC infrared transmitter. Sends leader, 32 data bits (LSB first)
//            and stop burst, then repeat codes every frame period while
//            repeat_req is held. Bursts are carrier-modulated.
// Revision : 1.0  initial release
// ============================================================================
module inf_send
    import inf_send_pkg::*;
#(
    parameter int unsigned CNT_CAR   = c_CNT_CAR,
    parameter int unsigned CNT_CAR_H = c_CNT_CAR_H,
    parameter int unsigned T_LEAD_H  = c_T_LEAD_H,
    parameter int unsigned T_LEAD_L  = c_T_LEAD_L,
    parameter int unsigned T_REP_L   = c_T_REP_L,
    parameter int unsigned T_BIT_H   = c_T_BIT_H,
    parameter int unsigned T_ZERO_L  = c_T_ZERO_L,
    parameter int unsigned T_ONE_L   = c_T_ONE_L,
    parameter int unsigned T_FRAME   = c_T_FRAME
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       send_en,
    input  logic       repeat_req,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       inf_out,
    output logic       busy,
    output logic       done
);

    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(T_FRAME - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_FRAME_W-1:0]   r_ph_cnt;
    logic [c_FRAME_W-1:0]   r_frame_cnt;
    logic [5:0]             r_bit_cnt;
    logic [31:0]            r_sreg;
    logic                   r_done;
    logic [c_FRAME_W-1:0]   w_dur;
    logic                   w_ph_end;
    logic                   w_accept;
    logic                   w_finish;
    logic                   w_restart;

    // Duration of the current state; the data space depends on the next bit
    always_comb begin
        w_dur = '0;
        case (r_state)
            S_LEAD_H, S_REP_H: w_dur = c_FRAME_W'(T_LEAD_H);
            S_LEAD_L:          w_dur = c_FRAME_W'(T_LEAD_L);
            S_REP_L:           w_dur = c_FRAME_W'(T_REP_L);
            S_BIT_H, S_STOP_H: w_dur = c_FRAME_W'(T_BIT_H);
            S_BIT_L:           w_dur = r_sreg[0] ? c_FRAME_W'(T_ONE_L) : c_FRAME_W'(T_ZERO_L);
            default:           w_dur = '0;
        endcase
        w_ph_end = (r_ph_cnt == (w_dur - 1'b1));
    end

    // Next-state logic; done pulse follows the GAP->IDLE transition
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done cycle is still IDLE but must not start a new frame
                if (send_en && !r_done) begin
                    w_next   = S_LEAD_H;
                    w_accept = 1'b1;
                end
            end
            S_LEAD_H: if (w_ph_end) w_next = S_LEAD_L;
            S_LEAD_L: if (w_ph_end) w_next = S_BIT_H;
            S_BIT_H:  if (w_ph_end) w_next = S_BIT_L;
            S_BIT_L:  if (w_ph_end) w_next = (r_bit_cnt == 6'd31) ? S_STOP_H : S_BIT_H;
            S_STOP_H: if (w_ph_end) w_next = S_GAP;
            S_GAP: begin
                if (r_frame_cnt == c_FRAME_LAST) begin
                    if (repeat_req) begin
                        w_next = S_REP_H;
                    end else begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end
                end
            end
            S_REP_H:  if (w_ph_end) w_next = S_REP_L;
            S_REP_L:  if (w_ph_end) w_next = S_STOP_H;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Phase counter restarts on every state change; frame counter on leader/repeat start
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ph_cnt    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_ph_cnt <= (w_next != r_state) ? '0 : r_ph_cnt + 1'b1;
            if (((w_next == S_LEAD_H) || (w_next == S_REP_H)) && (w_next != r_state)) begin
                r_frame_cnt <= '0;
            end else if (r_frame_cnt != '1) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Payload: load on accept, shift out LSB first at the end of every data space
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_sreg    <= {~data, data, ~addr, addr};
            r_bit_cnt <= '0;
        end else if ((r_state == S_BIT_L) && w_ph_end) begin
            r_sreg    <= {1'b0, r_sreg[31:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // One-cycle completion pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
        end
    end

    assign w_restart = is_burst(w_next) && (w_next != r_state);

    inf_carrier #(
        .CNT_CAR   (CNT_CAR),
        .CNT_CAR_H (CNT_CAR_H)
    ) u_carrier (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_restart (w_restart),
        .i_burst   (is_burst(r_state)),
        .o_out     (inf_out)
    );

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire
